// File: rtl/jt12_wr_sched_pkg.sv
// Shared state encoding and bus constants for the YM2612 write scheduler.
package jt12_wr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADR,
    ST_ADR_W,
    ST_DAT,
    ST_DAT_W,
    ST_POLL
  } state_e;

  localparam logic YM_ADDR_STROBE = 1'b0;
  localparam logic YM_DATA_STROBE = 1'b1;
  localparam int   YM_BUSY_BIT    = 7;

  // Width needed to hold the largest of the three wait/poll limits.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/jt12_wr_arb.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not granted last.
module jt12_wr_arb (
  input  logic [1:0] valid_i,
  input  logic       last_gnt_i,
  output logic       gnt_o,
  output logic       idx_o
);

  always_comb begin
    gnt_o = |valid_i;
    idx_o = (valid_i == 2'b11) ? ~last_gnt_i : valid_i[1];
  end

endmodule

// File: rtl/jt12_wr_sched.sv
// Round-robin Z80/68k write scheduler driving the FM core's cs_n/wr_n/addr/din pins.
// Optional status polling instead of a fixed data wait: define JT12_WR_SCHED_BUSY_POLL_EN.
module jt12_wr_sched
  import jt12_wr_sched_pkg::*;
#(
  parameter int ADDR_WAIT    = 2,
  parameter int DATA_WAIT    = 32,
  parameter int POLL_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       r0_valid,
  input  logic       r0_part,
  input  logic [7:0] r0_reg,
  input  logic [7:0] r0_data,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic       r1_part,
  input  logic [7:0] r1_reg,
  input  logic [7:0] r1_data,
  output logic       r1_ready,
  output logic [1:0] ym_addr,
  output logic [7:0] ym_din,
  output logic       ym_cs_n,
  output logic       ym_wr_n,
  input  logic [7:0] ym_dout,
  output logic       busy,
  output logic       last_gnt
);

  localparam int            CW        = cnt_width(ADDR_WAIT, DATA_WAIT, POLL_TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] ADDR_LOAD = CW'(ADDR_WAIT - 1);
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_TIMEOUT);
`else
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_WAIT - 1);
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          part_q, part_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          rdy0_q, rdy0_d;
  logic          rdy1_q, rdy1_d;
  logic          cs_n_q, cs_n_d;
  logic          wr_n_q, wr_n_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          busy_q, busy_d;
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
  logic          phase_q, phase_d;
`endif
  logic          arb_gnt, arb_idx;
  logic          unused_dout;

  assign unused_dout = ^ym_dout;

  jt12_wr_arb u_arb (
    .valid_i    ({r1_valid, r0_valid}),
    .last_gnt_i (last_q),
    .gnt_o      (arb_gnt),
    .idx_o      (arb_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      part_q  <= 1'b0;
      reg_q   <= 8'h00;
      data_q  <= 8'h00;
      last_q  <= 1'b1;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      addr_q  <= 2'b00;
      din_q   <= 8'h00;
      busy_q  <= 1'b0;
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      last_q  <= last_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
      phase_q <= phase_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    reg_d   = reg_q;
    data_d  = data_q;
    last_d  = last_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
    phase_d = phase_q;
`endif
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_gnt) begin
            part_d  = arb_idx ? r1_part : r0_part;
            reg_d   = arb_idx ? r1_reg  : r0_reg;
            data_d  = arb_idx ? r1_data : r0_data;
            last_d  = arb_idx;
            rdy0_d  = ~arb_idx;
            rdy1_d  = arb_idx;
            state_d = ST_ADR;
          end
        end
        ST_ADR: begin
          state_d = ST_ADR_W;
          cnt_d   = ADDR_LOAD;
        end
        ST_ADR_W: begin
          if (cnt_q == '0) state_d = ST_DAT;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        ST_DAT: begin
          state_d = ST_DAT_W;
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
          cnt_d   = '0;
`else
          cnt_d   = DATA_LOAD;
`endif
        end
        ST_DAT_W: begin
          if (cnt_q == '0) begin
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
            // cnt now counts status reads issued, starting with the first one.
            state_d = ST_POLL;
            cnt_d   = CNT_ONE;
            phase_d = 1'b0;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
        ST_POLL: begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (!ym_dout[YM_BUSY_BIT] || cnt_q == POLL_LAST) begin
            state_d = ST_IDLE;
          end else begin
            phase_d = 1'b0;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end

    // Bus pins are registered from the next state so each strobe spans exactly one cen period.
    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    addr_d = addr_q;
    din_d  = din_q;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_ADR: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        addr_d = {part_d, YM_ADDR_STROBE};
        din_d  = reg_d;
      end
      ST_DAT: begin
        cs_n_d = 1'b0;
        wr_n_d = 1'b0;
        addr_d = {part_d, YM_DATA_STROBE};
        din_d  = data_d;
      end
`ifdef JT12_WR_SCHED_BUSY_POLL_EN
      ST_POLL: begin
        if (!phase_d) begin
          cs_n_d = 1'b0;
          addr_d = 2'b00;
        end
      end
`endif
      default: ;
    endcase
  end

  assign r0_ready = rdy0_q;
  assign r1_ready = rdy1_q;
  assign ym_addr  = addr_q;
  assign ym_din   = din_q;
  assign ym_cs_n  = cs_n_q;
  assign ym_wr_n  = wr_n_q;
  assign busy     = busy_q;
  assign last_gnt = last_q;

endmodule
